// File: rtl/lfsr_prbs_checker_pkg.sv
// Shared types and constants for the serial PRBS checker.
package lfsr_prbs_checker_pkg;

   // Width of the externally visible error and bit counters.
   localparam int unsigned CNT_W = 16;

   // Alignment state of the checker.
   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/lfsr_prbs_checker_ref_lfsr.sv
// Local reference Galois LFSR; same update rule as the upstream generator,
// but only steps when Advance is high so the checker can slip bits.
module prbs_ref_lfsr #(
   parameter int unsigned          Length          = 8,
   parameter logic [Length-1:0]    Initial_State   = 8'b1001_0001,
   parameter logic [Length-1:0]    Tap_Coefficient = 8'b1111_0011
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Advance,
   output logic Y
);

   // Bit i holds cell i+1, so the output cell Ref[Length] is the MSB.
   logic [Length-1:0] ref_q;
   logic [Length-1:0] ref_d;

   // Next reference value: internal-XOR feedback from the last cell.
   always_comb begin
      ref_d = ref_q;
      if (Advance) begin
         ref_d[0] = ref_q[Length-1];
         for (int unsigned i = 1; i < Length; i++) begin
            ref_d[i] = ref_q[i-1] ^ (Tap_Coefficient[Length-i] & ref_q[Length-1]);
         end
      end
   end

   // Reference state register with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         ref_q <= Initial_State;
      end else begin
         ref_q <= ref_d;
      end
   end

   assign Y = ref_q[Length-1];

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Serial PRBS checker: bit-slip alignment to a Galois LFSR stream, then
// per-bit error flagging/counting with windowed loss-of-lock detection.
module lfsr_prbs_checker
   import lfsr_prbs_checker_pkg::*;
#(
   parameter int unsigned          Length          = 8,
   parameter logic [Length-1:0]    Initial_State   = 8'b1001_0001,
   parameter logic [Length-1:0]    Tap_Coefficient = 8'b1111_0011,
   parameter int unsigned          Lock_Count      = 16,
   parameter int unsigned          Window_Size     = 64,
   parameter int unsigned          Unlock_Errors   = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Bit_in,
   input  logic             Clear,
   output logic             Locked,
   output logic             Error,
   output logic [CNT_W-1:0] Error_Count,
   output logic [CNT_W-1:0] Bit_Count
);

   localparam int unsigned MC_W = $clog2(Lock_Count + 1);
   localparam int unsigned WB_W = $clog2(Window_Size);
   localparam int unsigned WE_W = $clog2(Unlock_Errors + 1);

   state_e            state_q, state_d;
   logic [MC_W-1:0]   match_q, match_d;
   logic [WB_W-1:0]   wbits_q, wbits_d;
   logic [WE_W-1:0]   werr_q,  werr_d;
   logic [WE_W-1:0]   werr_inc;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  ecnt_q,  ecnt_d;
   logic [CNT_W-1:0]  bcnt_q,  bcnt_d;
   logic              exp_bit;
   logic              mismatch;
   logic              advance;

   assign mismatch = Bit_in ^ exp_bit;
   // In SEARCH a mismatch holds the reference back one bit (the slip).
   assign advance  = Enable & ((state_q == LOCKED) | ~mismatch);

   prbs_ref_lfsr #(
      .Length          (Length),
      .Initial_State   (Initial_State),
      .Tap_Coefficient (Tap_Coefficient)
   ) u_ref (
      .Clock   (Clock),
      .Reset   (Reset),
      .Advance (advance),
      .Y       (exp_bit)
   );

   // Next-state, window and counter logic.
   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      wbits_d  = wbits_q;
      werr_d   = werr_q;
      werr_inc = werr_q;
      err_d    = 1'b0;
      ecnt_d   = ecnt_q;
      bcnt_d   = bcnt_q;

      if (Enable) begin
         if (state_q == SEARCH) begin
            if (!mismatch) begin
               if (match_q == MC_W'(Lock_Count - 1)) begin
                  state_d = LOCKED;
                  match_d = '0;
                  wbits_d = '0;
                  werr_d  = '0;
               end else begin
                  match_d = match_q + MC_W'(1);
               end
            end else begin
               match_d = '0;
            end
         end else begin
            if (bcnt_q != '1) begin
               bcnt_d = bcnt_q + CNT_W'(1);
            end
            if (mismatch) begin
               err_d    = 1'b1;
               werr_inc = werr_q + WE_W'(1);
               if (ecnt_q != '1) begin
                  ecnt_d = ecnt_q + CNT_W'(1);
               end
            end
            // Threshold is evaluated before the end-of-window clear.
            if (werr_inc == WE_W'(Unlock_Errors)) begin
               state_d = SEARCH;
               match_d = '0;
            end
            if (wbits_q == WB_W'(Window_Size - 1)) begin
               wbits_d = '0;
               werr_d  = '0;
            end else begin
               wbits_d = wbits_q + WB_W'(1);
               werr_d  = werr_inc;
            end
         end
      end

      if (Clear) begin
         ecnt_d = '0;
         bcnt_d = '0;
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= SEARCH;
         match_q <= '0;
         wbits_q <= '0;
         werr_q  <= '0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         wbits_q <= wbits_d;
         werr_q  <= werr_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign Locked      = (state_q == LOCKED);
   assign Error       = err_q;
   assign Error_Count = ecnt_q;
   assign Bit_Count   = bcnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Randomized bench for lfsr_prbs_checker against a sequence-table model.
module tb_lfsr_prbs_checker;

   localparam int unsigned L    = 8;
   localparam logic [7:0]  INIT = 8'b1001_0001;
   localparam logic [7:0]  TAP  = 8'b1111_0011;
   localparam int          LOCK = 16;
   localparam int          WIN  = 64;
   localparam int          UNL  = 4;
   localparam int          BUDGET = 6000;

   logic        Clock;
   logic        Reset;
   logic        Enable;
   logic        Bit_in;
   logic        Clear;
   logic        Locked;
   logic        Error;
   logic [15:0] Error_Count;
   logic [15:0] Bit_Count;

   lfsr_prbs_checker #(
      .Length          (L),
      .Initial_State   (INIT),
      .Tap_Coefficient (TAP),
      .Lock_Count      (LOCK),
      .Window_Size     (WIN),
      .Unlock_Errors   (UNL)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Enable      (Enable),
      .Bit_in      (Bit_in),
      .Clear       (Clear),
      .Locked      (Locked),
      .Error       (Error),
      .Error_Count (Error_Count),
      .Bit_Count   (Bit_Count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // One period of the generator output, and positions into it.
   bit seq [256];
   int period;
   int gpos;
   int rpos;

   // Behavioural checker state.
   bit m_lock, m_err;
   int mc, wb, we, m_ec, m_bc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Output sequence of the generator: state s steps as s<<1 ^ (msb ? mask : 0).
   task automatic build_seq();
      logic [7:0] s, mask, tap_v;
      bit fb;
      tap_v = TAP;
      mask  = 8'h01;
      for (int i = 1; i < 8; i++) mask[i] = tap_v[8-i];
      s = INIT;
      period = 0;
      do begin
         seq[period] = s[7];
         fb = s[7];
         s = {s[6:0], 1'b0};
         if (fb) s = s ^ mask;
         period++;
      end while (s != INIT && period < 256);
   endtask

   task automatic model_reset();
      rpos = 0; m_lock = 0; m_err = 0;
      mc = 0; wb = 0; we = 0; m_ec = 0; m_bc = 0;
   endtask

   task automatic model_bit(input bit en, input bit b, input bit clr);
      bit mis;
      m_err = 0;
      if (en) begin
         mis = (b != seq[rpos]);
         if (!m_lock) begin
            if (!mis) begin
               rpos = (rpos + 1) % period;
               mc++;
               if (mc == LOCK) begin
                  m_lock = 1; mc = 0; wb = 0; we = 0;
               end
            end else begin
               mc = 0;
            end
         end else begin
            rpos = (rpos + 1) % period;
            if (m_bc < 65535) m_bc++;
            if (mis) begin
               m_err = 1;
               if (m_ec < 65535) m_ec++;
               we++;
            end
            if (we == UNL) begin
               m_lock = 0; mc = 0;
            end
            if (wb == WIN - 1) begin
               wb = 0; we = 0;
            end else begin
               wb++;
            end
         end
      end
      if (clr) begin
         m_ec = 0; m_bc = 0;
      end
   endtask

   task automatic compare_all();
      check("locked",  32'(Locked),      32'(m_lock));
      check("error",   32'(Error),       32'(m_err));
      check("err_cnt", 32'(Error_Count), 32'(m_ec));
      check("bit_cnt", 32'(Bit_Count),   32'(m_bc));
   endtask

   task automatic step(input bit en, input bit flip, input bit clr);
      bit b;
      b      = en ? (seq[gpos] ^ flip) : 1'($urandom);
      Enable = en;
      Bit_in = b;
      Clear  = clr;
      @(posedge Clock);
      #1;
      model_bit(en, b, clr);
      if (en) gpos = (gpos + 1) % period;
      compare_all();
   endtask

   task automatic do_reset();
      Reset  = 1'b0;
      Enable = 1'($urandom);
      Bit_in = 1'($urandom);
      Clear  = 1'b0;
      @(posedge Clock);
      #1;
      Reset = 1'b1;
      model_reset();
      compare_all();
   endtask

   task automatic run_to_lock(input string tag);
      for (int i = 0; i < BUDGET && !m_lock; i++) step(1, 0, 0);
      check(tag, 32'(Locked), 32'd1);
   endtask

   task automatic run_to_wb(input int target);
      for (int i = 0; i < WIN && wb != target; i++) step(1, 0, 0);
   endtask

   initial begin
      Reset = 1'b0; Enable = 1'b0; Bit_in = 1'b0; Clear = 1'b0;
      build_seq();
      gpos = 0;
      model_reset();

      // Reset state
      do_reset();
      check("rst_locked", 32'(Locked), 32'd0);
      check("rst_errcnt", 32'(Error_Count), 32'd0);

      // Aligned lock in exactly LOCK bits
      gpos = 0;
      for (int i = 0; i < LOCK - 1; i++) step(1, 0, 0);
      check("aligned_not_yet", 32'(Locked), 32'd0);
      step(1, 0, 0);
      check("aligned_locked", 32'(Locked), 32'd1);
      for (int i = 0; i < 100; i++) step(1, 0, 0);
      check("aligned_bitcnt", 32'(Bit_Count), 32'd100);
      check("aligned_errcnt", 32'(Error_Count), 32'd0);

      // Single inverted bit
      step(1, 1, 0);
      check("single_pulse", 32'(Error), 32'd1);
      step(1, 0, 0);
      check("single_pulse_end", 32'(Error), 32'd0);
      check("single_errcnt", 32'(Error_Count), 32'd1);
      check("single_locked", 32'(Locked), 32'd1);

      // Four errors inside one window force loss of lock
      step(1, 0, 1);
      run_to_wb(0);
      for (int e = 0; e < UNL; e++) begin
         if (e == UNL - 1) check("unl_pre_locked", 32'(Locked), 32'd1);
         step(1, 1, 0);
         if (e < UNL - 1) for (int k = 0; k < 4; k++) step(1, 0, 0);
      end
      check("unl_dropped", 32'(Locked), 32'd0);
      check("unl_errcnt", 32'(Error_Count), 32'd4);

      // Relock, then 3 errors, window wrap, 1 error keeps lock
      run_to_lock("relock1");
      step(1, 0, 1);
      run_to_wb(WIN - 4);
      for (int e = 0; e < 3; e++) step(1, 1, 0);
      step(1, 0, 0);
      check("wrap_wb", 32'(wb), 32'd0);
      step(1, 1, 0);
      check("wrap_locked", 32'(Locked), 32'd1);
      check("wrap_errcnt", 32'(Error_Count), 32'd4);

      // Clear coincident with an error
      step(1, 1, 1);
      check("clr_pulse", 32'(Error), 32'd1);
      check("clr_errcnt", 32'(Error_Count), 32'd0);

      // Offset lock: generator five bits ahead
      do_reset();
      gpos = 5;
      run_to_lock("offset_lock");
      check("offset_errcnt", 32'(Error_Count), 32'd0);
      for (int i = 0; i < 200; i++) step(1, 0, 0);
      check("offset_errcnt_200", 32'(Error_Count), 32'd0);

      // Random Enable gaps, clean stream
      for (int i = 0; i < 1500; i++) step(($urandom_range(0, 9) < 7), 0, 0);
      check("gaps_locked", 32'(Locked), 32'd1);
      check("gaps_errcnt", 32'(Error_Count), 32'd0);

      // Random gaps, errors and clears
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 1));

      // Reset while locked
      run_to_lock("pre_reset_lock");
      do_reset();
      check("midrst_locked", 32'(Locked), 32'd0);
      check("midrst_error", 32'(Error), 32'd0);
      check("midrst_errcnt", 32'(Error_Count), 32'd0);
      check("midrst_bitcnt", 32'(Bit_Count), 32'd0);
      run_to_lock("post_reset_lock");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Serial PRBS checker that sits directly downstream of the team's internal-XOR (Galois) LFSR generator. It consumes the generator's serial output bit Y[Length] and aligns a local reference LFSR to the stream by bit-slipping. Once locked, it flags and counts bit errors and drops lock when the error density exceeds a threshold. Used for BIST of serial links and datapaths driven by the generator.

## Interface
- Length, 8, LFSR length; must equal the generator's.
- Initial_State, 8'b1001_0001, reference LFSR value after reset; must be nonzero.
- Tap_Coefficient, 8'b1111_0011, tap vector; must equal the generator's.
- Lock_Count, 16, consecutive matches required to lock (≥2).
- Window_Size, 64, valid bits per error-density window (≥2).
- Unlock_Errors, 4, errors within one window that force loss of lock (≥1).
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset.
- Enable  input  1  Bit_in valid this cycle.
- Bit_in  input  1  serial stream (generator Y[Length]).
- Clear  input  1  synchronous clear of Error_Count and Bit_Count.
- Locked  output  1  checker aligned.
- Error  output  1  one-cycle pulse per mismatched bit while locked.
- Error_Count  output  16  saturating error count.
- Bit_Count  output  16  saturating count of bits checked while locked.

## Operation
- Reference update, identical to the generator:
  - For cell k = 2..Length, Ref[k] <= Ref[k-1] ^ (Tap_Coefficient[Length-k+1] & Ref[Length]).
  - Ref[1] <= Ref[Length].
  - Expected bit = Ref[Length].
- Reset (Reset==0 at an edge):
  - Ref = Initial_State; state SEARCH.
  - All counters, Locked, Error, Error_Count and Bit_Count = 0.
- Enable=0: all state holds. Error=0.
- SEARCH, with Enable=1:
  - Match: advance Ref; match_cnt++. When the Lock_Count-th consecutive match is sampled, go to LOCKED, clear match_cnt, win_bits and win_err.
  - Mismatch: do not advance Ref (one-bit slip); match_cnt=0.
  - No Error pulses and no counter updates in SEARCH.
- LOCKED, with Enable=1:
  - Always advance Ref. Bit_Count++ (saturates at 16'hFFFF).
  - Mismatch: Error=1, Error_Count++ (saturates), win_err++.
  - Threshold: if win_err reaches Unlock_Errors, go to SEARCH, Locked=0, clear match_cnt. Ref keeps advancing normally on that edge.
  - Window: win_bits counts 0..Window_Size-1, then wraps to 0 and clears win_err. The threshold check on the last bit of a window happens before the clear.
- Clear: has priority over an increment in the same cycle, so the counters become 0. The Error pulse is still issued and the window logic is unaffected.

## Timing
- Error: registered; high in the cycle after the edge that sampled the mismatched bit.
- Locked: rises in the cycle after the edge that samples the Lock_Count-th consecutive match. Falls in the cycle after the edge that samples the Unlock_Errors-th windowed error; that error also pulses Error and increments Error_Count.
- Counters: Error_Count and Bit_Count are updated on the same edge as the bit they account for.
- Alignment time: generator aligned from reset locks in exactly Lock_Count enabled bits. An offset of d bits needs at least d slips. Total alignment time is bounded by the sequence period times (Lock_Count+1).
- Throughput: one bit per cycle; no back-pressure.

## Structure
- Shared package: state enum (SEARCH, LOCKED) and the counter width constant CNT_W=16.
- Sub-module prbs_ref_lfsr:
  - Parameters: Length, Initial_State, Tap_Coefficient.
  - Ports: Clock, Reset, Advance, Y.
  - Implements the reference update.
- Top level owns the FSM, match/window counters and the output counters.

## Test plan
- Aligned lock: generator and checker released from reset together, Enable=1 → Locked rises after exactly 16 bits; Error never pulses; after 100 more bits Bit_Count=100.
- Offset lock: generator started 5 bits ahead → Locked eventually 1 with Error_Count=0; subsequent 200 bits produce no Error.
- Single error: after lock, invert one Bit_in → exactly one Error pulse one cycle later; Error_Count=1; Locked stays 1.
- Unlock threshold:
  - 4 inverted bits within one 64-bit window → Locked falls after the 4th; Error_Count=4.
  - 3 errors, window wraps, then 1 error → Locked stays 1.
- Enable gaps and Clear:
  - Random Enable=0 gaps → counts and alignment unaffected.
  - Clear coincident with an error → Error_Count=0, Error pulses.
- Reset mid-lock: Reset=0 for one edge while LOCKED → Locked, Error, Error_Count and Bit_Count all 0; relock follows.
